// File: rtl/reg_bank_pn_pkg.sv
// Shared constants for the indexed register bank: opcode values and FSM state encoding.
package reg_bank_pn_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP    = 4'd0;
  localparam logic [OP_W-1:0] OP_LDI    = 4'd1;
  localparam logic [OP_W-1:0] OP_CLR    = 4'd2;
  localparam logic [OP_W-1:0] OP_INC    = 4'd3;
  localparam logic [OP_W-1:0] OP_DEC    = 4'd4;
  localparam logic [OP_W-1:0] OP_MOV    = 4'd5;
  localparam logic [OP_W-1:0] OP_CLRALL = 4'd6;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank_pn_alu.sv
// Combinational next-value unit for a single register write; owns the modular wrap arithmetic.
module reg_bank_pn_alu
  import reg_bank_pn_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic [OP_W-1:0]      op,
  input  logic [DataWidth-1:0] cur,
  input  logic [DataWidth-1:0] src,
  input  logic [DataWidth-1:0] imm,
  output logic [DataWidth-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (op)
      OP_LDI:  nxt = imm;
      OP_CLR:  nxt = '0;
      // Truncation to DataWidth gives the wrap to 0 / all-ones.
      OP_INC:  nxt = cur + DataWidth'(1);
      OP_DEC:  nxt = cur - DataWidth'(1);
      OP_MOV:  nxt = src;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/reg_bank_pn.sv
// Indexed register bank with single-issue instruction port, registered readback and sticky error state.
module reg_bank_pn
  import reg_bank_pn_pkg::*;
#(
  parameter  int RegCount  = 4,
  parameter  int DataWidth = 8,
  localparam int IdxWidth  = $clog2(RegCount),
  localparam int InstWidth = OP_W + IdxWidth + DataWidth
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [InstWidth-1:0]          inst,
  input  logic                          inst_en,
  input  logic [IdxWidth-1:0]           rd_idx,
  output logic [DataWidth-1:0]          rd_data,
  output logic [RegCount*DataWidth-1:0] out,
  output logic                          ready,
  output logic                          error,
  output state_t                        state
);

  logic [DataWidth-1:0] regs      [RegCount];
  logic [DataWidth-1:0] next_regs [RegCount];
  state_t               next_state;

  logic [OP_W-1:0]      op;
  logic [IdxWidth-1:0]  idx;
  logic [IdxWidth-1:0]  src_idx;
  logic [DataWidth-1:0] imm;
  logic [DataWidth-1:0] alu_nxt;

  assign op      = inst[InstWidth-1 -: OP_W];
  assign idx     = inst[DataWidth +: IdxWidth];
  assign imm     = inst[DataWidth-1:0];
  assign src_idx = imm[IdxWidth-1:0];

  reg_bank_pn_alu #(.DataWidth(DataWidth)) u_alu (
    .op  (op),
    .cur (regs[idx]),
    .src (regs[src_idx]),
    .imm (imm),
    .nxt (alu_nxt)
  );

  always_comb begin
    next_state = state;
    next_regs  = regs;
    case (state)
      ST_RESET: next_state = ST_READY;
      ST_READY: begin
        if (inst_en) begin
          if (op > OP_CLRALL) begin
            next_state = ST_ERROR;
            for (int k = 0; k < RegCount; k++) next_regs[k] = '0;
          end else if (op == OP_CLRALL) begin
            for (int k = 0; k < RegCount; k++) next_regs[k] = '0;
          end else begin
            // NOP falls through the ALU unchanged, so one write path covers ops 0..5.
            next_regs[idx] = alu_nxt;
          end
        end
      end
      ST_ERROR: begin
        for (int k = 0; k < RegCount; k++) next_regs[k] = '0;
      end
      default: begin
        next_state = ST_ERROR;
        for (int k = 0; k < RegCount; k++) next_regs[k] = '0;
      end
    endcase
  end

  // Readback samples the post-update value so rd_data lines up with out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_RESET;
      rd_data <= '0;
      for (int k = 0; k < RegCount; k++) regs[k] <= '0;
    end else begin
      state   <= next_state;
      rd_data <= next_regs[rd_idx];
      regs    <= next_regs;
    end
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < RegCount; k++) out[k*DataWidth +: DataWidth] = regs[k];
  end

  assign ready = (state == ST_READY);
  assign error = (state == ST_ERROR);

endmodule

// File: tb/tb_reg_bank_pn.sv
// Directed test for reg_bank_pn at RegCount=4, DataWidth=8 with hand-computed expectations.
module tb_reg_bank_pn;
  import reg_bank_pn_pkg::*;

  logic        clock;
  logic        reset;
  logic [13:0] inst;
  logic        inst_en;
  logic [1:0]  rd_idx;
  logic [7:0]  rd_data;
  logic [31:0] out;
  logic        ready;
  logic        error;
  state_t      state;

  int vectors;
  int miscompares;

  reg_bank_pn #(.RegCount(4), .DataWidth(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .inst    (inst),
    .inst_en (inst_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .out     (out),
    .ready   (ready),
    .error   (error),
    .state   (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] idx,
                                     input logic [7:0] imm);
    return {op, idx, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue(input logic [13:0] i, input logic en);
    inst    = i;
    inst_en = en;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    inst        = '0;
    inst_en     = 1'b0;
    rd_idx      = 2'd0;

    // 1. async reset mid-cycle, then first edge ignores an enabled LDI
    #3 reset = 1'b0;
    #1;
    check("rst_out", out, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_rd", {24'b0, rd_data}, 32'd0);
    check("rst_state", {30'b0, state}, {30'b0, ST_RESET});
    @(negedge clock);
    reset = 1'b1;
    issue(mk(4'd1, 2'd2, 8'hA5), 1'b1);
    check("start_ready", {31'b0, ready}, 32'd1);
    check("start_ignored", out, 32'h0);

    // 2. loads and readback
    rd_idx = 2'd2;
    issue(mk(4'd1, 2'd2, 8'hA5), 1'b1);
    check("ldi_r2", out, 32'h00A5_0000);
    check("rd_r2", {24'b0, rd_data}, 32'hA5);
    issue(mk(4'd1, 2'd0, 8'h3C), 1'b1);
    check("ldi_r0", out, 32'h00A5_003C);
    rd_idx = 2'd0;
    issue('0, 1'b0);
    check("rd_r0", {24'b0, rd_data}, 32'h3C);
    check("hold_idle", out, 32'h00A5_003C);

    // 3. wrap arithmetic
    issue(mk(4'd1, 2'd1, 8'hFF), 1'b1);
    check("ldi_r1", out, 32'h00A5_FF3C);
    issue(mk(4'd3, 2'd1, 8'h00), 1'b1);
    check("inc_wrap", out, 32'h00A5_003C);
    issue(mk(4'd4, 2'd1, 8'h00), 1'b1);
    check("dec_wrap", out, 32'h00A5_FF3C);
    rd_idx = 2'd3;
    issue(mk(4'd4, 2'd3, 8'h12), 1'b1);
    check("dec_r3", out, 32'hFFA5_FF3C);
    check("rd_r3", {24'b0, rd_data}, 32'hFF);

    // 6. inst_en gating
    issue(mk(4'd9, 2'd0, 8'h00), 1'b0);
    check("gate_err", {31'b0, error}, 32'd0);
    check("gate_ready", {31'b0, ready}, 32'd1);
    issue(mk(4'd1, 2'd0, 8'h55), 1'b0);
    check("gate_ldi", out, 32'hFFA5_FF3C);

    // 4. MOV and CLRALL
    issue(mk(4'd1, 2'd0, 8'h11), 1'b1);
    issue(mk(4'd1, 2'd3, 8'h77), 1'b1);
    check("pre_mov", out, 32'h77A5_FF11);
    issue(mk(4'd5, 2'd0, 8'h03), 1'b1);
    check("mov_r3_r0", out, 32'h77A5_FF77);
    issue(mk(4'd5, 2'd2, 8'h02), 1'b1);
    check("mov_self", out, 32'h77A5_FF77);
    issue(mk(4'd2, 2'd1, 8'hEE), 1'b1);
    check("clr_r1", out, 32'h77A5_0077);
    issue(mk(4'd0, 2'd3, 8'h99), 1'b1);
    check("nop", out, 32'h77A5_0077);
    issue(mk(4'd6, 2'd0, 8'h00), 1'b1);
    check("clrall", out, 32'h0);

    // 5. sticky error and recovery
    rd_idx = 2'd2;
    issue(mk(4'd1, 2'd2, 8'h42), 1'b1);
    check("pre_err", out, 32'h0042_0000);
    issue(mk(4'd9, 2'd0, 8'h00), 1'b1);
    check("err_flag", {31'b0, error}, 32'd1);
    check("err_ready", {31'b0, ready}, 32'd0);
    check("err_out", out, 32'h0);
    check("err_rd", {24'b0, rd_data}, 32'h0);
    issue(mk(4'd1, 2'd1, 8'h12), 1'b1);
    check("err_sticky", out, 32'h0);
    check("err_state", {30'b0, state}, {30'b0, ST_ERROR});
    #2 reset = 1'b0;
    #1;
    check("rerst_error", {31'b0, error}, 32'd0);
    check("rerst_ready", {31'b0, ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    issue('0, 1'b0);
    check("recover_ready", {31'b0, ready}, 32'd1);
    issue(mk(4'd1, 2'd3, 8'h5A), 1'b1);
    check("recover_ldi", out, 32'h5A00_0000);

    // reset landing on a pending instruction drops it
    inst    = mk(4'd1, 2'd0, 8'h66);
    inst_en = 1'b1;
    #2 reset = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    check("rst_drop", out, 32'h0);
    inst_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
